calendar_date_unit: RTL and testbench

//  Calendar stage directly downstream of the day counter in the clock chain.

---
 rtl/clock_pkg.sv | 27 ++
 rtl/month_len.sv | 20 ++
 rtl/calendar_date_unit.sv | 131 +++++++++++++
 tb/tb_calendar_date_unit.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared constants for the clock chain: load-select codes, reset values and
// month numbers used by the calendar stage.
package clock_pkg;

  localparam logic [1:0] LOAD_DATE  = 2'b00;
  localparam logic [1:0] LOAD_MONTH = 2'b01;
  localparam logic [1:0] LOAD_YEAR  = 2'b10;
  localparam logic [1:0] LOAD_RSVD  = 2'b11;

  localparam logic [4:0] DATE_RST  = 5'd1;
  localparam logic [3:0] MONTH_RST = 4'd1;
  localparam int         YEAR_RST  = 0;

  localparam logic [3:0] JAN = 4'd1;
  localparam logic [3:0] FEB = 4'd2;
  localparam logic [3:0] MAR = 4'd3;
  localparam logic [3:0] APR = 4'd4;
  localparam logic [3:0] MAY = 4'd5;
  localparam logic [3:0] JUN = 4'd6;
  localparam logic [3:0] JUL = 4'd7;
  localparam logic [3:0] AUG = 4'd8;
  localparam logic [3:0] SEP = 4'd9;
  localparam logic [3:0] OCT = 4'd10;
  localparam logic [3:0] NOV = 4'd11;
  localparam logic [3:0] DEC = 4'd12;

endpackage

// File: rtl/month_len.sv
// Number of days in a month; out-of-range month numbers report 31 so a forced
// bad month still rolls over at a sensible point.
module month_len
  import clock_pkg::*;
(
  input  logic [3:0] month,
  input  logic       leap,
  output logic [4:0] len
);

  always_comb begin
    len = 5'd31;
    case (month)
      APR, JUN, SEP, NOV: len = 5'd30;
      FEB:                len = leap ? 5'd29 : 5'd28;
      default:            len = 5'd31;
    endcase
  end

endmodule

// File: rtl/calendar_date_unit.sv
// Date/month/year stage fed by the day-rollover carry, with validated field
// loads from the shared databus and registered carry/error pulses.
module calendar_date_unit
  import clock_pkg::*;
#(
  parameter int YEAR_W   = 6,
  parameter int LEAP_MOD = 4
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              enable,
  input  logic              load,
  input  logic [1:0]        load_sel,
  input  logic [5:0]        databus,
  input  logic              day_carry,
  output logic [4:0]        date,
  output logic [3:0]        month,
  output logic [YEAR_W-1:0] year,
  output logic              date_carry,
  output logic              month_carry,
  output logic              year_carry,
  output logic              load_err
);

  localparam logic [YEAR_W-1:0] YEAR_MAX = {YEAR_W{1'b1}};

  logic [YEAR_W-1:0] year_v;
  logic              cur_leap;
  logic              cand_leap;
  logic [3:0]        cand_month;
  logic [4:0]        cur_len;
  logic [4:0]        cand_len;
  logic              load_ok;
  logic [4:0]        ld_date;
  logic [3:0]        ld_month;
  logic [YEAR_W-1:0] ld_year;

  assign year_v   = YEAR_W'(databus);
  assign cur_leap = (int'(year) % LEAP_MOD) == 0;

  // The candidate length is for the month/year pair that a load would produce.
  assign cand_month = (load_sel == LOAD_YEAR) ? month : databus[3:0];
  assign cand_leap  = (load_sel == LOAD_YEAR) ? ((int'(year_v) % LEAP_MOD) == 0) : cur_leap;

  month_len u_len_cur (
    .month (month),
    .leap  (cur_leap),
    .len   (cur_len)
  );

  month_len u_len_cand (
    .month (cand_month),
    .leap  (cand_leap),
    .len   (cand_len)
  );

  always_comb begin
    load_ok  = 1'b0;
    ld_date  = date;
    ld_month = month;
    ld_year  = year;
    case (load_sel)
      LOAD_DATE: begin
        if (databus != 6'd0 && databus <= 6'(cur_len)) begin
          load_ok = 1'b1;
          ld_date = databus[4:0];
        end
      end
      LOAD_MONTH: begin
        if (databus != 6'd0 && databus <= 6'(DEC)) begin
          load_ok  = 1'b1;
          ld_month = databus[3:0];
          if (date > cand_len) ld_date = cand_len;
        end
      end
      LOAD_YEAR: begin
        load_ok = 1'b1;
        ld_year = year_v;
        // Only 29 Feb can exceed the new month length when the year changes.
        if (date > cand_len) ld_date = cand_len;
      end
      default: load_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      date        <= DATE_RST;
      month       <= MONTH_RST;
      year        <= YEAR_W'(YEAR_RST);
      date_carry  <= 1'b0;
      month_carry <= 1'b0;
      year_carry  <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      date_carry  <= 1'b0;
      month_carry <= 1'b0;
      year_carry  <= 1'b0;
      load_err    <= 1'b0;
      if (load) begin
        if (load_ok) begin
          date  <= ld_date;
          month <= ld_month;
          year  <= ld_year;
        end else begin
          load_err <= 1'b1;
        end
      end else if (enable && day_carry) begin
        if (date < cur_len) begin
          date <= date + 5'd1;
        end else begin
          date       <= DATE_RST;
          date_carry <= 1'b1;
          if (month < DEC) begin
            month <= month + 4'd1;
          end else begin
            month       <= MONTH_RST;
            month_carry <= 1'b1;
            if (year == YEAR_MAX) begin
              year       <= YEAR_W'(YEAR_RST);
              year_carry <= 1'b1;
            end else begin
              year <= year + 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_calendar_date_unit.sv
// Directed-vector bench: each step pushes its hand-computed expected outputs
// into a queue; a negedge monitor pops and compares them.
module tb_calendar_date_unit;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       enable = 1'b0;
  logic       load = 1'b0;
  logic [1:0] load_sel = 2'b00;
  logic [5:0] databus = 6'd0;
  logic       day_carry = 1'b0;
  logic [4:0] date;
  logic [3:0] month;
  logic [5:0] year;
  logic       date_carry, month_carry, year_carry, load_err;

  typedef struct {
    int   d, m, y;
    logic dc, mc, yc, err;
    int   tag;
  } exp_t;

  exp_t q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   tag_n = 0;

  calendar_date_unit #(.YEAR_W(6), .LEAP_MOD(4)) dut (
    .clk         (clk),
    .clear       (clear),
    .enable      (enable),
    .load        (load),
    .load_sel    (load_sel),
    .databus     (databus),
    .day_carry   (day_carry),
    .date        (date),
    .month       (month),
    .year        (year),
    .date_carry  (date_carry),
    .month_carry (month_carry),
    .year_carry  (year_carry),
    .load_err    (load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      compared++;
      if (int'(date) != e.d || int'(month) != e.m || int'(year) != e.y ||
          date_carry !== e.dc || month_carry !== e.mc ||
          year_carry !== e.yc || load_err !== e.err) begin
        mismatched++;
        $display("FAIL step%0d: got %0d/%0d/%0d dc%b mc%b yc%b err%b, want %0d/%0d/%0d dc%b mc%b yc%b err%b",
                 e.tag, date, month, year, date_carry, month_carry, year_carry, load_err,
                 e.d, e.m, e.y, e.dc, e.mc, e.yc, e.err);
      end
    end
  end

  // Drive one cycle of inputs; if chk, queue the outputs expected after the edge.
  task automatic step(input bit chk, input logic c, input logic ld, input logic [1:0] sel,
                      input int bus, input logic en, input logic dcy,
                      input int ed, input int em, input int ey, input logic [3:0] p);
    exp_t e;
    @(negedge clk);
    #1;
    clear     = c;
    load      = ld;
    load_sel  = sel;
    databus   = 6'(bus);
    enable    = en;
    day_carry = dcy;
    if (chk) begin
      tag_n++;
      e.d = ed; e.m = em; e.y = ey;
      e.dc = p[3]; e.mc = p[2]; e.yc = p[1]; e.err = p[0];
      e.tag = tag_n;
      q.push_back(e);
    end
  endtask

  task automatic ld(input logic [1:0] sel, input int bus, input int ed, input int em,
                    input int ey, input logic err);
    step(1, 0, 1, sel, bus, 0, 0, ed, em, ey, {3'b000, err});
  endtask

  task automatic adv(input int ed, input int em, input int ey, input logic [2:0] c);
    step(1, 0, 0, 2'b00, 0, 1, 1, ed, em, ey, {c, 1'b0});
  endtask

  task automatic idle(input int ed, input int em, input int ey);
    step(1, 0, 0, 2'b00, 0, 1, 0, ed, em, ey, 4'b0000);
  endtask

  initial begin
    // Put the DUT into an arbitrary legal state, unchecked.
    step(0, 0, 1, 2'b10, 37, 0, 0, 0, 0, 0, 4'b0);
    step(0, 0, 1, 2'b01, 7, 0, 0, 0, 0, 0, 4'b0);
    step(0, 0, 1, 2'b00, 15, 0, 0, 0, 0, 0, 4'b0);
    // 1 Reset
    step(1, 1, 0, 2'b00, 0, 1, 1, 1, 1, 0, 4'b0000);
    step(0, 0, 1, 2'b00, 20, 0, 0, 0, 0, 0, 4'b0);
    step(1, 1, 1, 2'b00, 9, 1, 1, 1, 1, 0, 4'b0000);
    step(1, 1, 1, 2'b01, 5, 0, 0, 1, 1, 0, 4'b0000);
    // 2 Month end
    ld(2'b01, 1, 1, 1, 0, 0);
    ld(2'b00, 31, 31, 1, 0, 0);
    adv(1, 2, 0, 3'b100);
    idle(1, 2, 0);
    // 3 Leap
    ld(2'b10, 4, 1, 2, 4, 0);
    ld(2'b00, 28, 28, 2, 4, 0);
    adv(29, 2, 4, 3'b000);
    adv(1, 3, 4, 3'b100);
    idle(1, 3, 4);
    ld(2'b01, 2, 1, 2, 4, 0);
    ld(2'b10, 5, 1, 2, 5, 0);
    ld(2'b00, 28, 28, 2, 5, 0);
    ld(2'b00, 29, 28, 2, 5, 1);
    adv(1, 3, 5, 3'b100);
    // 4 Full wrap
    ld(2'b10, 63, 1, 3, 63, 0);
    ld(2'b01, 12, 1, 12, 63, 0);
    ld(2'b00, 31, 31, 12, 63, 0);
    adv(1, 1, 0, 3'b111);
    idle(1, 1, 0);
    // Month wrap without year wrap
    ld(2'b01, 12, 1, 12, 0, 0);
    ld(2'b00, 31, 31, 12, 0, 0);
    adv(1, 1, 1, 3'b110);
    // 5 Load checks
    ld(2'b01, 4, 1, 4, 1, 0);
    ld(2'b00, 31, 1, 4, 1, 1);
    ld(2'b00, 30, 30, 4, 1, 0);
    ld(2'b01, 2, 28, 2, 1, 0);
    ld(2'b01, 13, 28, 2, 1, 1);
    ld(2'b01, 0, 28, 2, 1, 1);
    ld(2'b00, 0, 28, 2, 1, 1);
    ld(2'b00, 29, 28, 2, 1, 1);
    ld(2'b10, 4, 28, 2, 4, 0);
    ld(2'b00, 29, 29, 2, 4, 0);
    ld(2'b10, 5, 28, 2, 5, 0);
    ld(2'b11, 9, 28, 2, 5, 1);
    ld(2'b10, 63, 28, 2, 63, 0);
    ld(2'b10, 8, 28, 2, 8, 0);
    ld(2'b01, 1, 28, 1, 8, 0);
    ld(2'b01, 2, 28, 2, 8, 0);
    // 30-day month end
    ld(2'b01, 4, 28, 4, 8, 0);
    ld(2'b00, 30, 30, 4, 8, 0);
    adv(1, 5, 8, 3'b100);
    // 6 Contention
    step(1, 0, 1, 2'b00, 10, 1, 1, 10, 5, 8, 4'b0000);
    step(1, 0, 1, 2'b00, 31, 1, 1, 31, 5, 8, 4'b0000);
    step(1, 0, 1, 2'b11, 3, 1, 1, 31, 5, 8, 4'b0001);
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 2'b00, 0, 0, 1, 31, 5, 8, 4'b0000);
      step(1, 0, 0, 2'b00, 0, 0, 0, 31, 5, 8, 4'b0000);
    end
    adv(1, 6, 8, 3'b100);
    adv(2, 6, 8, 3'b000);
    // Return to idle and drain with a bounded wait.
    @(negedge clk);
    #1;
    load = 1'b0; enable = 1'b0; day_carry = 1'b0; clear = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      mismatched++;
      $display("FAIL drain: %0d expected entries left unchecked, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
